// File: rtl/swd_pkg.sv
// Shared definitions for the SWD host engine: ACK codes, FSM states,
// phase lengths and request-header bit positions.
package swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int LRST_BITS = 56;
  localparam int REQ_BITS  = 8;
  localparam int ACK_BITS  = 3;
  localparam int DATA_BITS = 33;  // 32 data bits followed by one parity bit

  // Request header bit positions, transmitted LSB first
  localparam int HDR_START  = 0;
  localparam int HDR_APNDP  = 1;
  localparam int HDR_RNW    = 2;
  localparam int HDR_A2     = 3;
  localparam int HDR_A3     = 4;
  localparam int HDR_PARITY = 5;
  localparam int HDR_STOP   = 6;
  localparam int HDR_PARK   = 7;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LRST, ST_REQ, ST_TRN1, ST_ACK,
    ST_RDATA, ST_TRN2, ST_WDATA, ST_TAIL, ST_DONE
  } swd_state_e;

  function automatic logic [7:0] build_hdr(input logic apndp, input logic rnw,
                                           input logic [1:0] addr);
    logic [7:0] hdr;
    hdr             = '0;
    hdr[HDR_START]  = 1'b1;
    hdr[HDR_APNDP]  = apndp;
    hdr[HDR_RNW]    = rnw;
    hdr[HDR_A2]     = addr[0];
    hdr[HDR_A3]     = addr[1];
    hdr[HDR_PARITY] = apndp ^ rnw ^ addr[0] ^ addr[1];
    hdr[HDR_STOP]   = 1'b0;
    hdr[HDR_PARK]   = 1'b1;
    return hdr;
  endfunction

endpackage

// File: rtl/swd_clkgen.sv
// SWCLK divider. Each SWD bit is 2*CLK_DIV system cycles, low half first.
// The end-of-bit cycle raises both strobes: SWDIO_I is captured there and
// the engine steps to the next bit, so new drive values appear as SWCLK falls.
module swd_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic swclk_o,
  output logic fall_stb_o,
  output logic sample_stb_o
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          swclk_q;
  logic          bit_end;

  // Next phase count; pinned at zero while stopped so every transaction
  // opens with a full low half-period.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
    cnt_d = '0;
    if (run_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // Phase counter plus a registered, glitch-free SWCLK.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      cnt_q   <= '0;
      swclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      swclk_q <= (cnt_d >= HALF);
    end
  end

  assign bit_end      = run_i && (cnt_q == LAST);
  assign swclk_o      = swclk_q;
  assign fall_stb_o   = bit_end;
  assign sample_stb_o = bit_end;

endmodule

// File: rtl/swd_host.sv
// SWD host engine: serialises a DP/AP request, handles turnaround, ACK,
// data and parity, and returns a one-cycle response. SWDIO is exposed as
// separate O/OE/I signals.
module swd_host
  import swd_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic        CLK_SYS,
  input  logic        SYS_RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_LRST,
  input  logic        REQ_APNDP,
  input  logic        REQ_RNW,
  input  logic [1:0]  REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [2:0]  RSP_ACK,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_PERR,
  output logic        SWCLK,
  output logic        SWDIO_O,
  output logic        SWDIO_OE,
  input  logic        SWDIO_I
);

  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  swd_state_e  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  last_idx;
  logic [7:0]  hdr_q;
  logic [31:0] wdata_q;
  logic        rnw_q;
  logic [2:0]  ack_q;
  logic [2:0]  ack_shift;
  logic [31:0] rdata_q;
  logic        perr_q;
  logic        run, bit_stb, sample_stb, bit_last;

  assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

  swd_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i        (CLK_SYS),
    .rst_i        (SYS_RST),
    .run_i        (run),
    .swclk_o      (SWCLK),
    .fall_stb_o   (bit_stb),
    .sample_stb_o (sample_stb)
  );

  // ACK arrives LSB first; this is the complete code as its last bit is sampled.
  assign ack_shift = {SWDIO_I, ack_q[2:1]};

  // Index of the final bit of the current phase.
  always_comb begin
    last_idx = '0;
    case (state_q)
      ST_LRST:            last_idx = 6'(LRST_BITS - 1);
      ST_REQ:             last_idx = 6'(REQ_BITS - 1);
      ST_ACK:             last_idx = 6'(ACK_BITS - 1);
      ST_RDATA, ST_WDATA: last_idx = DATA_LAST;
      ST_TAIL:            last_idx = 6'(IDLE_CYCLES - 1);
      default:            last_idx = '0;
    endcase
  end

  assign bit_last = bit_stb && (bit_cnt_q == last_idx);

  // FSM state register.
  always_ff @(posedge CLK_SYS or posedge SYS_RST) begin
    if (SYS_RST) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, bit counter and SWDIO drive for the current bit.
  always_comb begin
    state_d  = state_q;
    SWDIO_O  = 1'b0;
    SWDIO_OE = 1'b1;
    case (state_q)
      ST_IDLE:  if (REQ_VALID) state_d = REQ_LRST ? ST_LRST : ST_REQ;
      ST_LRST: begin
        SWDIO_O = 1'b1;
        if (bit_last) state_d = ST_TAIL;
      end
      ST_REQ: begin
        SWDIO_O = hdr_q[bit_cnt_q[2:0]];
        if (bit_last) state_d = ST_TRN1;
      end
      ST_TRN1: begin
        SWDIO_OE = 1'b0;
        if (bit_last) state_d = ST_ACK;
      end
      ST_ACK: begin
        SWDIO_OE = 1'b0;
        if (bit_last) state_d = (ack_shift == ACK_OK && rnw_q) ? ST_RDATA : ST_TRN2;
      end
      ST_RDATA: begin
        SWDIO_OE = 1'b0;
        if (bit_last) state_d = ST_TRN2;
      end
      ST_TRN2: begin
        SWDIO_OE = 1'b0;
        if (bit_last) state_d = (ack_q == ACK_OK && !rnw_q) ? ST_WDATA : ST_TAIL;
      end
      ST_WDATA: begin
        SWDIO_O = (bit_cnt_q == DATA_LAST) ? ^wdata_q : wdata_q[bit_cnt_q[4:0]];
        if (bit_last) state_d = ST_TAIL;
      end
      ST_TAIL:  if (bit_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Counter restarts at every phase entry and otherwise counts bits.
    if (state_d != state_q) bit_cnt_d = '0;
    else if (bit_stb)       bit_cnt_d = bit_cnt_q + 6'd1;
    else                    bit_cnt_d = bit_cnt_q;
  end

  // Request capture on handshake and sampling of ACK / read data.
  always_ff @(posedge CLK_SYS or posedge SYS_RST) begin
    if (SYS_RST) begin
      bit_cnt_q <= '0;
      hdr_q     <= '0;
      wdata_q   <= '0;
      rnw_q     <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      if (state_q == ST_IDLE && REQ_VALID) begin
        hdr_q   <= build_hdr(REQ_APNDP, REQ_RNW, REQ_ADDR);
        wdata_q <= REQ_WDATA;
        rnw_q   <= REQ_RNW;
        ack_q   <= '0;
        rdata_q <= '0;
        perr_q  <= 1'b0;
      end else if (sample_stb) begin
        if (state_q == ST_ACK) ack_q <= ack_shift;
        if (state_q == ST_RDATA) begin
          if (bit_cnt_q == DATA_LAST) perr_q <= SWDIO_I ^ (^rdata_q);
          else                        rdata_q <= {SWDIO_I, rdata_q[31:1]};
        end
      end
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign RSP_VALID = (state_q == ST_DONE);
  assign RSP_ACK   = ack_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_PERR  = perr_q;

endmodule

// File: tb/tb_swd_host.sv
// Self-checking bench for swd_host: a wire-level SWD target model answers
// each request, expected responses are queued when a request is issued and
// compared when RSP_VALID pulses.
module tb_swd_host;
  import swd_pkg::*;

  localparam int CLK_DIV     = 3;
  localparam int IDLE_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_lrst = 1'b0, req_apndp = 1'b0, req_rnw = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        swdio_i = 1'b1;
  logic        req_ready, rsp_valid, rsp_perr, swclk, swdio_o, swdio_oe;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  swd_host #(.CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES)) dut (
    .CLK_SYS(clk), .SYS_RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_LRST(req_lrst),
    .REQ_APNDP(req_apndp), .REQ_RNW(req_rnw), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_ACK(rsp_ack), .RSP_RDATA(rsp_rdata), .RSP_PERR(rsp_perr),
    .SWCLK(swclk), .SWDIO_O(swdio_o), .SWDIO_OE(swdio_oe), .SWDIO_I(swdio_i)
  );

  typedef struct packed {
    logic [2:0]  ack;
    logic [31:0] rdata;
    logic        perr;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Target behaviour for wire bit n: ACK on bits 9..11, then read data and
  // parity on bits 12..44 when the request was a read and the ACK is OK.
  function automatic logic model_bit(input int n, input logic rnw_seen, input logic [2:0] ack,
                                     input logic [31:0] rd, input logic rpar);
    if (n >= 9 && n <= 11) return ack[n-9];
    if (ack == ACK_OK && rnw_seen && n >= 12 && n <= 43) return rd[n-12];
    if (ack == ACK_OK && rnw_seen && n == 44) return rpar;
    return 1'b1;
  endfunction

  task automatic run_txn(input string name, input logic lrst, input logic apndp,
                         input logic rnw, input logic [1:0] addr, input logic [31:0] wdata,
                         input logic [7:0] exp_hdr, input logic [2:0] tgt_ack,
                         input logic [31:0] tgt_rdata, input logic tgt_rpar,
                         input int abort_bit, input logic poke_busy);
    logic        okr, okw, got, prev, seen;
    int          exp_bits, nbits, since_rise;
    logic [63:0] o_bits, oe_bits, exp_oe;
    logic [7:0]  hdr;
    logic [32:0] wcap;
    rsp_t        e, r;

    okr      = !lrst && tgt_ack == ACK_OK && rnw;
    okw      = !lrst && tgt_ack == ACK_OK && !rnw;
    exp_bits = lrst ? LRST_BITS + IDLE_CYCLES : ((tgt_ack == ACK_OK) ? 46 : 13) + IDLE_CYCLES;
    exp_oe   = '0;
    for (int n = 0; n < exp_bits && n < 64; n++)
      exp_oe[n] = !(!lrst && n >= 8 && n <= (okr ? 45 : 12));
    if (abort_bit == 0) begin
      e.ack   = lrst ? 3'b000 : tgt_ack;
      e.rdata = okr ? tgt_rdata : 32'h0;
      e.perr  = okr && (tgt_rpar != ^tgt_rdata);
      sb.push_back(e);
    end

    @(negedge clk);
    check({name, ":ready"}, req_ready, 1);
    req_lrst = lrst; req_apndp = apndp; req_rnw = rnw; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;

    nbits = 0; got = 1'b0; prev = 1'b0; since_rise = 0;
    o_bits = '0; oe_bits = '0; hdr = '0; wcap = '0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      if (swclk && !prev) begin
        if (nbits < 64) begin
          o_bits[nbits]  = swdio_o;
          oe_bits[nbits] = swdio_oe;
        end
        if (nbits < 8) hdr[nbits] = swdio_o;
        if (nbits >= 13 && nbits <= 45) wcap[nbits-13] = swdio_o;
        swdio_i = model_bit(nbits, hdr[2], tgt_ack, tgt_rdata, tgt_rpar);
        nbits++;
        since_rise = 0;
        if (abort_bit != 0 && nbits == abort_bit) begin
          #2 rst = 1'b1;
          #1;
          check({name, ":rst_ready"}, req_ready, 1);
          check({name, ":rst_swclk"}, swclk, 0);
          check({name, ":rst_oe"}, swdio_oe, 1);
          check({name, ":rst_o"}, swdio_o, 0);
          check({name, ":rst_rsp"}, {rsp_valid, rsp_ack, rsp_rdata, rsp_perr}, 0);
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
          swdio_i = 1'b1;
          seen = 1'b0;
          repeat (600) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
          end
          check({name, ":no_rsp"}, seen, 0);
          check({name, ":idle_again"}, req_ready, 1);
          return;
        end
      end else begin
        since_rise++;
      end
      prev = swclk;
      req_valid = poke_busy && nbits == 5 && since_rise < 3;
      if (req_valid) check({name, ":busy"}, req_ready, 0);
      if (rsp_valid) begin
        got = 1'b1;
        check({name, ":rsp_lat"}, since_rise, CLK_DIV);
        if (sb.size() == 0) begin
          check({name, ":unexpected_rsp"}, 1, 0);
        end else begin
          r = sb.pop_front();
          check({name, ":ack"}, rsp_ack, r.ack);
          check({name, ":rdata"}, rsp_rdata, r.rdata);
          check({name, ":perr"}, rsp_perr, r.perr);
        end
      end
      if (!got) @(negedge clk);
    end
    req_valid = 1'b0;

    check({name, ":done"}, got, 1);
    check({name, ":bits"}, nbits, exp_bits);
    check({name, ":oe"}, oe_bits, exp_oe);
    if (lrst) check({name, ":lrst_o"}, o_bits, 64'h00FF_FFFF_FFFF_FFFF);
    else      check({name, ":hdr"}, hdr, exp_hdr);
    if (okw) check({name, ":wdata"}, wcap, {^wdata, wdata});
    @(negedge clk);
    check({name, ":pulse"}, rsp_valid, 0);
    check({name, ":ready_after"}, req_ready, 1);
  endtask

  initial begin
    logic [31:0] rnd;
    logic        seen;

    repeat (2) @(negedge clk);
    check("reset:ready", req_ready, 1);
    check("reset:rsp", {rsp_valid, rsp_ack, rsp_rdata, rsp_perr}, 0);
    check("reset:swclk", swclk, 0);
    check("reset:o", swdio_o, 0);
    check("reset:oe", swdio_oe, 1);
    rst = 1'b0;
    @(negedge clk);

    run_txn("idcode",    0, 0, 1, 2'd0, 32'h0,        8'hA5, ACK_OK,    32'h2BA01477, 1'b0, 0, 0);
    run_txn("abort_wr",  0, 0, 0, 2'd0, 32'h0000001E, 8'h81, ACK_OK,    32'h0,        1'b0, 0, 0);
    run_txn("ap_wait",   0, 1, 1, 2'd3, 32'h0,        8'h9F, ACK_WAIT,  32'hDEADBEEF, 1'b0, 0, 0);
    run_txn("perr",      0, 0, 1, 2'd1, 32'h0,        8'h8D, ACK_OK,    32'h00000001, 1'b0, 0, 0);
    run_txn("lrst",      1, 0, 0, 2'd0, 32'h0,        8'h00, ACK_OK,    32'h0,        1'b0, 0, 0);
    run_txn("fault_wr",  0, 1, 0, 2'd1, 32'hCAFEF00D, 8'h8B, ACK_FAULT, 32'h0,        1'b0, 0, 0);
    run_txn("proto_err", 0, 0, 1, 2'd2, 32'h0,        8'h95, 3'b111,    32'h12345678, 1'b0, 0, 0);
    run_txn("rst_abort", 0, 0, 1, 2'd0, 32'h0,        8'hA5, ACK_OK,    32'h2BA01477, 1'b0, 20, 0);
    run_txn("after_rst", 0, 0, 1, 2'd0, 32'h0,        8'hA5, ACK_OK,    32'h2BA01477, 1'b0, 0, 1);
    rnd = $urandom;
    run_txn("ap_wr_rnd", 0, 1, 0, 2'd2, rnd,          8'h93, ACK_OK,    32'h0,        1'b0, 0, 0);
    rnd = $urandom;
    run_txn("rdbuff",    0, 0, 1, 2'd3, 32'h0,        8'hBD, ACK_OK,    rnd,          ^rnd, 0, 0);

    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("tail_quiet", seen, 0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swd_host.md
# swd_host

SWD host (debug-probe side) engine that drives SWCLK/SWDIO toward the Cortex-M3 debug port so on-chip logic can perform DP/AP register reads and writes without an external probe. A transaction is accepted on a valid/ready request port. The engine serialises the 8-bit request, handles turnaround, ACK, 32-bit data and parity, and returns a single-cycle response. SWDIO is split into O/OE/I; the tristate buffer sits in the top level.

## Interface
Parameters:
- CLK_DIV, 4, SWCLK half-period in CLK_SYS cycles (≥1); one SWD bit = 2*CLK_DIV cycles
- IDLE_CYCLES, 8, SWD bits driven low after every transaction and after line reset (≥1)

Ports:
- CLK_SYS  in  1  system clock; the only clock in the block
- SYS_RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request strobe
- REQ_READY  out  1  high only in IDLE
- REQ_LRST  in  1  1 = line-reset sequence; other request fields ignored
- REQ_APNDP  in  1  0 = DP, 1 = AP
- REQ_RNW  in  1  1 = read
- REQ_ADDR  in  2  A[3:2]
- REQ_WDATA  in  32  write data
- RSP_VALID  out  1  one-cycle response pulse
- RSP_ACK  out  3  sampled ACK (OK=001, WAIT=010, FAULT=100); 000 for line reset
- RSP_RDATA  out  32  read data; 0 unless OK read
- RSP_PERR  out  1  read-data parity mismatch
- SWCLK  out  1  SWD clock
- SWDIO_O  out  1  host drive value
- SWDIO_OE  out  1  1 = host drives SWDIO
- SWDIO_I  in  1  SWDIO pin value, pre-synchronised externally

## Operation
- States: IDLE, LRST, REQ, TRN1, ACK, RDATA, TRN2, WDATA, TAIL, DONE.
- IDLE: SWCLK=0, OE=1, O=0. A handshake occurs when REQ_VALID&&REQ_READY; the request is registered on that handshake.
- LRST: 56 bits of O=1, then TAIL.
- REQ: 8 bits, LSB first: Start=1, APnDP, RnW, A2, A3, Parity=^{APnDP,RnW,A[2],A[3]}, Stop=0, Park=1.
- TRN1: 1 bit with OE=0.
- ACK: 3 bits sampled LSB first, OE=0.
- ACK=001 and read: RDATA runs 32 data bits plus 1 parity bit, LSB first, sampled. PERR = parity ≠ ^data. Then TRN2, then TAIL.
- ACK=001 and write: TRN2, then WDATA drives 32 bits plus parity=^WDATA, OE=1, then TAIL.
- Any other ACK (WAIT, FAULT, protocol error): TRN2, then TAIL. No data phase and no retry; retry is the caller's job.
- TAIL: IDLE_CYCLES bits with O=0, OE=1, then DONE.
- DONE: RSP_* valid for 1 cycle, then IDLE.
- Bit counter is 6 bits wide and is reloaded on each state entry.

## Timing
- Bit phase: the first CLK_DIV cycles have SWCLK=0, the next CLK_DIV cycles have SWCLK=1.
- O and OE change only on the cycle SWCLK falls, or on the first low cycle of a bit.
- SWDIO_I is sampled on the last high cycle of the bit, i.e. just before SWCLK falls.
- OE goes to 0 at the start of the TRN1 bit. OE returns to 1 at the start of the bit after TRN2, or at the start of WDATA.
- Bus length in bits:
  - OK read: 46 + IDLE_CYCLES
  - OK write: 46 + IDLE_CYCLES
  - non-OK: 13 + IDLE_CYCLES
  - line reset: 56 + IDLE_CYCLES
- RSP_VALID rises 1 cycle after the final TAIL bit. REQ_READY re-asserts on the cycle after RSP_VALID.
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_ACK=0, RSP_RDATA=0, RSP_PERR=0, SWCLK=0, SWDIO_O=0, SWDIO_OE=1.
- Reset asserted mid-transaction forces these values immediately and aborts with no response.
- REQ_VALID while busy is ignored; no queueing.

## Structure
- swd_pkg holds:
  - ACK codes (ACK_OK, ACK_WAIT, ACK_FAULT)
  - state enum
  - LRST_BITS=56
  - request-header field positions
- Sub-module swd_clkgen: divider producing SWCLK plus one-cycle fall_stb and sample_stb. It is held in reset/stopped while the engine is in IDLE.

## Test plan
- DP read of IDCODE (APnDP=0, RnW=1, ADDR=0):
  - request byte on the wire is 0xA5
  - model ACKs 001 and returns 0x2BA01477 with parity 0
  - response: RSP_ACK=001, RSP_RDATA=0x2BA01477, RSP_PERR=0
  - 46+8 bits total
- DP write ABORT (ADDR=0, RnW=0, WDATA=0x0000001E):
  - request byte 0x81
  - model captures 0x1E with parity 0
  - RSP_ACK=001
- AP read, model returns WAIT (010):
  - transaction ends after 13+8 bits
  - OE=0 only across TRN1, ACK and TRN2
  - RSP_ACK=010, RSP_RDATA=0
- Read returns 0x00000001 with parity bit 0 -> RSP_PERR=1, RSP_RDATA=0x00000001.
- REQ_LRST=1 -> 56 bits with O=1, then 8 bits with O=0; RSP_ACK=000.
- SYS_RST pulsed during RDATA:
  - outputs take reset values asynchronously
  - no RSP_VALID
  - the next request completes normally
